// File: rtl/ifu_fetch.sv
// Instruction fetch unit: one 64-bit AXI read per instruction, delivering a 32-bit word and its PC.
// Latency: IFU_vld 3 cycles after ifetch_req with a zero-wait slave (1 cycle on a line-buffer hit).
// Backpressure: AR held stable until AR_READY and R_READY held until R_VALID; ifetch_req is sampled only in S_WAIT.
// Optional: define IFU_LINE_BUF_EN for a one-entry line buffer that skips AXI when the next PC is in the last line read.
module ifu_fetch #(
  parameter logic [63:0] RESET_PC = 64'h80000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ifetch_req,
  input  logic        ifetch_taken,
  input  logic [63:0] ifetch_taken_pc,
  output logic [63:0] axi_AR_ADDR,
  output logic        axi_AR_VALID,
  input  logic        axi_AR_READY,
  input  logic [63:0] axi_R_DATA,
  input  logic        axi_R_VALID,
  output logic        axi_R_READY,
  output logic        IFU_vld,
  output logic [63:0] IFU_pc,
  output logic [31:0] IFU_inst
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_AR   = 3'd1,
    S_R    = 3'd2,
    S_OUT  = 3'd3,
    S_WAIT = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [63:0] r_pc;
  logic [63:0] r_ifu_pc;
  logic [31:0] r_ifu_inst;
  logic [63:0] w_target;
  logic [63:0] w_next_pc;
  logic        w_req_take;
  logic        w_r_fire;
  logic [31:0] w_r_inst;

  // The PC only moves on an accepted request; its low two bits are always cleared.
  assign w_target   = ifetch_taken ? ifetch_taken_pc : (r_pc + 64'd4);
  assign w_next_pc  = w_target & ~64'd3;
  assign w_req_take = (r_state == S_WAIT) && ifetch_req;
  assign w_r_fire   = (r_state == S_R) && axi_R_VALID;
  assign w_r_inst   = r_pc[2] ? axi_R_DATA[63:32] : axi_R_DATA[31:0];

`ifdef IFU_LINE_BUF_EN
  logic        r_buf_vld;
  logic [60:0] r_buf_tag;
  logic [63:0] r_buf_dat;
  logic        w_buf_hit;
  logic [31:0] w_buf_inst;

  assign w_buf_hit  = r_buf_vld && (r_buf_tag == w_next_pc[63:3]);
  assign w_buf_inst = w_next_pc[2] ? r_buf_dat[63:32] : r_buf_dat[31:0];

  // Remember the most recent line returned by the slave; reset invalidates it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_buf_vld <= 1'b0;
      r_buf_tag <= '0;
      r_buf_dat <= '0;
    end else if (w_r_fire) begin
      r_buf_vld <= 1'b1;
      r_buf_tag <= r_pc[63:3];
      r_buf_dat <= axi_R_DATA;
    end
  end
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: AR handshake, R beat, one-cycle delivery, then wait for the retire request.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: w_state_nxt = S_AR;
      S_AR:   if (axi_AR_READY) w_state_nxt = S_R;
      S_R:    if (axi_R_VALID) w_state_nxt = S_OUT;
      S_OUT:  w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (ifetch_req) begin
`ifdef IFU_LINE_BUF_EN
          w_state_nxt = w_buf_hit ? S_OUT : S_AR;
`else
          w_state_nxt = S_AR;
`endif
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Fetch PC: advance or redirect only when a request is accepted in S_WAIT.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc <= RESET_PC;
    end else if (w_req_take) begin
      r_pc <= w_next_pc;
    end
  end

  // Delivered instruction/PC: loaded from the R beat (or buffer) and held between pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ifu_pc   <= RESET_PC;
      r_ifu_inst <= '0;
    end else if (w_r_fire) begin
      r_ifu_pc   <= r_pc;
      r_ifu_inst <= w_r_inst;
`ifdef IFU_LINE_BUF_EN
    end else if (w_req_take && w_buf_hit) begin
      r_ifu_pc   <= w_next_pc;
      r_ifu_inst <= w_buf_inst;
`endif
    end
  end

  assign axi_AR_VALID = (r_state == S_AR);
  assign axi_AR_ADDR  = axi_AR_VALID ? {r_pc[63:3], 3'b000} : 64'd0;
  assign axi_R_READY  = (r_state == S_R);
  assign IFU_vld      = (r_state == S_OUT);
  assign IFU_pc       = r_ifu_pc;
  assign IFU_inst     = r_ifu_inst;

endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: lock-step AXI slave plus a line-level reference model.
// The model tracks the architectural PC and the last line read; expected data comes from a memory function.
module tb_ifu_fetch;

  localparam logic [63:0] RST_PC = 64'h80000000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ifetch_req = 1'b0;
  logic        ifetch_taken = 1'b0;
  logic [63:0] ifetch_taken_pc = '0;
  logic [63:0] axi_AR_ADDR;
  logic        axi_AR_VALID;
  logic        axi_AR_READY = 1'b0;
  logic [63:0] axi_R_DATA = '0;
  logic        axi_R_VALID = 1'b0;
  logic        axi_R_READY;
  logic        IFU_vld;
  logic [63:0] IFU_pc;
  logic [31:0] IFU_inst;

  int checks = 0;
  int errors = 0;

  logic [63:0] m_pc;
  logic        m_buf_vld;
  logic [60:0] m_buf_tag;

  ifu_fetch #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .rst_n(rst_n),
    .ifetch_req(ifetch_req), .ifetch_taken(ifetch_taken), .ifetch_taken_pc(ifetch_taken_pc),
    .axi_AR_ADDR(axi_AR_ADDR), .axi_AR_VALID(axi_AR_VALID), .axi_AR_READY(axi_AR_READY),
    .axi_R_DATA(axi_R_DATA), .axi_R_VALID(axi_R_VALID), .axi_R_READY(axi_R_READY),
    .IFU_vld(IFU_vld), .IFU_pc(IFU_pc), .IFU_inst(IFU_inst)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] mem(input logic [63:0] a);
    logic [63:0] l;
    l = {a[63:3], 3'b000};
    if (l == 64'h80000000) return 64'h00100073_00000413;
    return {l[31:0] ^ 32'hdeadbeef, l[31:0] + l[63:32] + 32'h01010101};
  endfunction

  function automatic logic [31:0] sel(input logic [63:0] d, input logic hi);
    return hi ? d[63:32] : d[31:0];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_req();
    ifetch_req      = 1'($urandom % 2);
    ifetch_taken    = 1'($urandom % 2);
    ifetch_taken_pc = {$urandom, $urandom};
  endtask

  task automatic chk_out();
    chk("out_vld", 64'(IFU_vld), 64'd1);
    chk("out_pc", IFU_pc, m_pc);
    chk("out_inst", 64'(IFU_inst), 64'(sel(mem(m_pc), m_pc[2])));
    chk("out_no_ar", 64'(axi_AR_VALID), 64'd0);
  endtask

  // Entered with the DUT in S_AR; returns with the DUT in S_WAIT.
  task automatic serve(input int ar_wait, input int r_wait);
    logic [63:0] addr;
    addr = {m_pc[63:3], 3'b000};
    for (int i = 0; i < ar_wait; i++) begin
      chk("ar_vld_hold", 64'(axi_AR_VALID), 64'd1);
      chk("ar_addr_hold", axi_AR_ADDR, addr);
      chk("ar_no_rrdy", 64'(axi_R_READY), 64'd0);
      chk("ar_no_vld", 64'(IFU_vld), 64'd0);
      axi_AR_READY = 1'b0;
      axi_R_VALID  = 1'($urandom % 2);
      axi_R_DATA   = {$urandom, $urandom};
      rand_req();
      tick();
    end
    // Handshake cycle also carries a bogus R beat that must be dropped.
    axi_AR_READY = 1'b1;
    axi_R_VALID  = 1'b1;
    axi_R_DATA   = ~mem(addr);
    rand_req();
    chk("ar_vld", 64'(axi_AR_VALID), 64'd1);
    chk("ar_addr", axi_AR_ADDR, addr);
    tick();
    axi_AR_READY = 1'b0;
    axi_R_VALID  = 1'b0;
    for (int i = 0; i < r_wait; i++) begin
      chk("r_rdy_hold", 64'(axi_R_READY), 64'd1);
      chk("r_no_dup_ar", 64'(axi_AR_VALID), 64'd0);
      chk("r_no_vld", 64'(IFU_vld), 64'd0);
      rand_req();
      tick();
    end
    axi_R_VALID = 1'b1;
    axi_R_DATA  = mem(addr);
    rand_req();
    chk("r_rdy", 64'(axi_R_READY), 64'd1);
    tick();
    axi_R_VALID = 1'b0;
    axi_R_DATA  = {$urandom, $urandom};
    m_buf_vld   = 1'b1;
    m_buf_tag   = m_pc[63:3];
    chk_out();
    rand_req();
    tick();
    ifetch_req   = 1'b0;
    ifetch_taken = 1'b0;
    chk("wait_no_vld", 64'(IFU_vld), 64'd0);
    chk("wait_hold_pc", IFU_pc, m_pc);
    chk("wait_hold_inst", 64'(IFU_inst), 64'(sel(mem(m_pc), m_pc[2])));
  endtask

  // Entered with the DUT in S_WAIT; issues one retire request and completes the fetch.
  task automatic request(input logic taken, input logic [63:0] tpc, input int ar_wait, input int r_wait);
    int idle;
    idle = $urandom_range(0, 2);
    for (int i = 0; i < idle; i++) begin
      chk("idle_no_ar", 64'(axi_AR_VALID), 64'd0);
      chk("idle_no_vld", 64'(IFU_vld), 64'd0);
      tick();
    end
    ifetch_req      = 1'b1;
    ifetch_taken    = taken;
    ifetch_taken_pc = tpc;
    tick();
    ifetch_req   = 1'b0;
    ifetch_taken = 1'b0;
    m_pc = (taken ? tpc : m_pc + 64'd4) & ~64'd3;
`ifdef IFU_LINE_BUF_EN
    if (m_buf_vld && m_buf_tag == m_pc[63:3]) begin
      chk_out();
      tick();
      chk("hit_no_vld", 64'(IFU_vld), 64'd0);
      chk("hit_no_ar", 64'(axi_AR_VALID), 64'd0);
    end else begin
      serve(ar_wait, r_wait);
    end
`else
    serve(ar_wait, r_wait);
`endif
  endtask

  initial begin
    m_pc      = RST_PC;
    m_buf_vld = 1'b0;
    m_buf_tag = '0;
    tick();
    tick();
    chk("rst_ar_vld", 64'(axi_AR_VALID), 64'd0);
    chk("rst_r_rdy", 64'(axi_R_READY), 64'd0);
    chk("rst_vld", 64'(IFU_vld), 64'd0);
    chk("rst_pc", IFU_pc, RST_PC);
    chk("rst_inst", 64'(IFU_inst), 64'd0);
    chk("rst_ar_addr", axi_AR_ADDR, 64'd0);
    rst_n = 1'b1;
    tick();
    serve(0, 0);
    // Sequential fetch in the same line, then a redirect to the upper half of another line.
    request(1'b0, 64'd0, 0, 0);
    request(1'b1, 64'h80000104, 0, 0);
    // Slow slave: AR stalled 5 cycles, R delayed 4.
    request(1'b1, 64'h80000040, 5, 4);
    // Misaligned target and 64-bit wraparound.
    request(1'b1, 64'hFFFFFFFFFFFFFFFE, 1, 1);
    request(1'b0, 64'd0, 0, 2);
    request(1'b0, 64'd0, 0, 0);
    // Randomized stream of sequential and redirected fetches.
    for (int n = 0; n < 40; n++) begin
      request(1'($urandom % 3 == 0), RST_PC + 64'($urandom_range(0, 255)),
              $urandom_range(0, 3), $urandom_range(0, 3));
    end
    // Reset while waiting for R, followed by a stale beat.
    ifetch_req      = 1'b1;
    ifetch_taken    = 1'b1;
    ifetch_taken_pc = 64'h80002000;
    tick();
    ifetch_req   = 1'b0;
    ifetch_taken = 1'b0;
    axi_AR_READY = 1'b1;
    chk("abort_ar_addr", axi_AR_ADDR, 64'h80002000);
    tick();
    axi_AR_READY = 1'b0;
    chk("abort_in_r", 64'(axi_R_READY), 64'd1);
    rst_n = 1'b0;
    tick();
    rst_n       = 1'b1;
    axi_R_VALID = 1'b1;
    axi_R_DATA  = {$urandom, $urandom};
    chk("abort_r_rdy", 64'(axi_R_READY), 64'd0);
    chk("abort_no_vld", 64'(IFU_vld), 64'd0);
    chk("abort_pc", IFU_pc, RST_PC);
    chk("abort_inst", 64'(IFU_inst), 64'd0);
    tick();
    chk("stale_r_rdy", 64'(axi_R_READY), 64'd0);
    chk("stale_no_vld", 64'(IFU_vld), 64'd0);
    m_pc      = RST_PC;
    m_buf_vld = 1'b0;
    serve(1, 1);
    request(1'b0, 64'd0, 0, 0);
    request(1'b1, 64'h80000104, 2, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ifu_fetch.md
IFU_FETCH -- requirements
Module: ifu_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 64'h80000000, giving the first fetch address after reset.
REQ-002 SHALL have port clk  input  1  clock; all state updates on the posedge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port ifetch_req  input  1  execute stage has retired the current instruction; fetch the next one.
REQ-005 SHALL have port ifetch_taken  input  1  the next PC is redirected (qualified by ifetch_req).
REQ-006 SHALL have port ifetch_taken_pc  input  64  redirect target.
REQ-007 SHALL have port axi_AR_ADDR  output  64  read address.
REQ-008 SHALL have port axi_AR_VALID  output  1  read address valid.
REQ-009 SHALL have port axi_AR_READY  input  1  read address ready.
REQ-010 SHALL have port axi_R_DATA  input  64  read data beat.
REQ-011 SHALL have port axi_R_VALID  input  1  read data valid.
REQ-012 SHALL have port axi_R_READY  output  1  read data ready.
REQ-013 SHALL have port IFU_vld  output  1  one-cycle pulse marking a new instruction.
REQ-014 SHALL have port IFU_pc  output  64  PC of the delivered instruction.
REQ-015 SHALL have port IFU_inst  output  32  delivered instruction word.

Function
REQ-016 SHALL implement FSM states S_IDLE, S_AR, S_R, S_OUT, S_WAIT, with reset state S_IDLE.
REQ-017 S_IDLE SHALL advance unconditionally to S_AR on the first clock edge with rst_n=1.
REQ-018 In S_AR, axi_AR_VALID SHALL be 1 and axi_AR_ADDR SHALL be {pc[63:3],3'b000}, both held stable until axi_AR_READY; on AR handshake -> S_R.
REQ-019 In S_R, axi_R_READY SHALL be 1; on axi_R_VALID, SHALL capture IFU_inst = pc[2] ? R_DATA[63:32] : R_DATA[31:0] and IFU_pc = pc, then -> S_OUT.
REQ-020 axi_AR_VALID SHALL be 0 outside S_AR, and axi_R_READY SHALL be 0 outside S_R.
REQ-021 In S_OUT, IFU_vld SHALL be 1 for exactly one cycle, then -> S_WAIT.
REQ-022 In S_WAIT with ifetch_req=1, pc SHALL become ifetch_taken ? ifetch_taken_pc : pc+4 (64-bit wrap), with pc[1:0] forced to 0; next state is S_AR (or S_OUT per REQ-029).
REQ-023 ifetch_req SHALL be ignored in every state other than S_WAIT.
REQ-024 IFU_pc and IFU_inst SHALL hold their values between IFU_vld pulses.
REQ-025 With a zero-wait slave, IFU_vld SHALL assert 3 cycles after the ifetch_req cycle (WAIT->AR->R->OUT).
REQ-026 axi_R_VALID arriving in the same cycle as the AR handshake SHALL be ignored; data is accepted only in S_R.

Reset
REQ-027 While rst_n=0: state = S_IDLE, pc = RESET_PC, IFU_vld = 0, IFU_pc = RESET_PC, IFU_inst = 0, axi_AR_VALID = 0, axi_R_READY = 0, axi_AR_ADDR = 0.
REQ-028 Reset asserted mid-transaction SHALL abandon the transaction with no completion; a late R beat after reset SHALL NOT be accepted until a new AR handshake completes.

Configuration
REQ-029 With macro IFU_LINE_BUF_EN defined, the block SHALL keep a one-entry buffer (64-bit data, tag pc[63:3], valid bit), filled on every R beat and cleared by reset.
- On a buffer hit in S_WAIT (valid and tag match on the new pc), the block SHALL load IFU_inst/IFU_pc from the buffer and go directly to S_OUT with no AXI traffic, so IFU_vld asserts 1 cycle after ifetch_req.
- The buffer is not coherent with stores; fence.i is unsupported.
REQ-030 Without IFU_LINE_BUF_EN, there SHALL be no buffer logic, and every fetch SHALL use AXI.

Verification
REQ-031 Reset release, slave returns 64'h00100073_00000413 at 0x80000000 -> AR_ADDR=0x80000000, IFU_vld pulse with IFU_pc=0x80000000, IFU_inst=0x00000413.
REQ-032 ifetch_req=1, ifetch_taken=0 after REQ-031 -> with the buffer: IFU_inst=0x00100073, no AR, IFU_vld 1 cycle later; without the buffer: AR_ADDR=0x80000000, IFU_vld 3 cycles later.
REQ-033 ifetch_req with ifetch_taken=1, ifetch_taken_pc=0x80000104 -> AR_ADDR=0x80000100, IFU_inst=R_DATA[63:32], IFU_pc=0x80000104.
REQ-034 AR_READY held low 5 cycles, then R_VALID delayed 4 cycles -> AR_VALID/ADDR stable throughout, a single IFU_vld pulse, no duplicate AR.
REQ-035 rst_n low for 1 cycle while in S_R, then a stale R_VALID -> stale beat ignored, a fresh AR to 0x80000000 issued, buffer invalid.
REQ-036 ifetch_req held high during S_AR/S_R -> no extra fetch, and the PC advances exactly once per S_WAIT request.
